// File: rtl/pwm_audio_out.sv
// Mono audio output stage: gain/saturate/attenuate sample path feeding a
// period-synchronous PWM, with slew-limited mute/underrun ramping to midscale.
module pwm_audio_out #(
  parameter int SAMPLE_W     = 16,
  parameter int PWM_W        = 8,
  parameter int SHIFT_W      = 4,
  parameter int RAMP_STEP    = 4,
  parameter int HOLD_PERIODS = 64
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                valid_in,
  input  logic [SHIFT_W-1:0]  shift_in,
  input  logic [2:0]          vol_in,
  input  logic                mute_in,
  output logic                pwm_out,
  output logic                aud_sd_out,
  output logic [PWM_W-1:0]    level_out,
  output logic                clip_out,
  output logic                underrun_out
);
  localparam int EXT_W  = SAMPLE_W + 2**SHIFT_W;
  localparam int IDLE_W = $clog2(HOLD_PERIODS + 1);
  localparam logic [PWM_W-1:0]  MID  = {1'b1, {(PWM_W-1){1'b0}}};
  localparam logic [PWM_W-1:0]  STEP = PWM_W'(RAMP_STEP);
  localparam logic [IDLE_W-1:0] HOLD = IDLE_W'(HOLD_PERIODS);
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {RUN, RAMP_DOWN, MUTED, RAMP_UP} state_t;

  state_t              state_q, state_d;
  logic [PWM_W-1:0]    cnt_q, level_q, level_d, target_q, target_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [SAMPLE_W-1:0] s1_q;
  logic                s1_clip_q, s1_vld_q;
  logic                pwm_q, clip_q;
  logic                bnd, em;

  // S1: widen, shift, clamp back to the sample range
  logic signed [EXT_W-1:0] ext, shl;
  logic [SAMPLE_W-1:0]     sat;
  logic                    sat_clip;
  always_comb begin
    ext      = {{(EXT_W-SAMPLE_W){sample_in[SAMPLE_W-1]}}, sample_in};
    shl      = ext <<< shift_in;
    sat      = shl[SAMPLE_W-1:0];
    sat_clip = 1'b0;
    if (shl > SAT_MAX) begin
      sat      = {1'b0, {(SAMPLE_W-1){1'b1}}};
      sat_clip = 1'b1;
    end else if (shl < SAT_MIN) begin
      sat      = {1'b1, {(SAMPLE_W-1){1'b0}}};
      sat_clip = 1'b1;
    end
  end

  // S2: top bits, attenuate, convert to offset binary
  logic signed [PWM_W-1:0] top, att;
  logic [2:0]              rsh;
  logic [PWM_W-1:0]        s2_lvl;
  always_comb begin
    top    = s1_q[SAMPLE_W-1 -: PWM_W];
    rsh    = 3'd7 - vol_in;
    att    = top >>> rsh;
    s2_lvl = {~att[PWM_W-1], att[PWM_W-2:0]};
  end

  assign bnd          = &cnt_q;
  assign underrun_out = (idle_q == HOLD);
  assign em           = mute_in | underrun_out;

  always_comb begin
    idle_d = idle_q;
    if (valid_in)                  idle_d = '0;
    else if (bnd && idle_q != HOLD) idle_d = idle_q + IDLE_W'(1);
  end

  always_comb begin
    target_d = target_q;
    if (underrun_out)  target_d = MID;
    else if (s1_vld_q) target_d = s2_lvl;
  end

  function automatic logic [PWM_W-1:0] step_to(input logic [PWM_W-1:0] cur,
                                               input logic [PWM_W-1:0] goal);
    if (cur < goal) return (goal - cur > STEP) ? cur + STEP : goal;
    else            return (cur - goal > STEP) ? cur - STEP : goal;
  endfunction

  // Level only moves at period boundaries, which keeps the PWM glitch-free
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (bnd) begin
      case (state_q)
        RUN: begin
          if (em) state_d = RAMP_DOWN;
          else    level_d = target_q;
        end
        RAMP_DOWN: begin
          level_d = step_to(level_q, MID);
          if (level_d == MID) state_d = MUTED;
          else if (!em)       state_d = RAMP_UP;
        end
        MUTED: begin
          level_d = MID;
          if (!em) state_d = RAMP_UP;
        end
        RAMP_UP: begin
          level_d = step_to(level_q, target_q);
          if (em)                       state_d = RAMP_DOWN;
          else if (level_d == target_q) state_d = RUN;
        end
        default: state_d = MUTED;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= MUTED;
      cnt_q     <= '0;
      level_q   <= MID;
      target_q  <= MID;
      idle_q    <= '0;
      s1_q      <= '0;
      s1_clip_q <= 1'b0;
      s1_vld_q  <= 1'b0;
      pwm_q     <= 1'b0;
      clip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_q + PWM_W'(1);
      level_q   <= level_d;
      target_q  <= target_d;
      idle_q    <= idle_d;
      s1_vld_q  <= valid_in;
      if (valid_in) begin
        s1_q      <= sat;
        s1_clip_q <= sat_clip;
      end
      pwm_q     <= (cnt_q < level_q);
      clip_q    <= s1_vld_q & s1_clip_q;
    end
  end

  assign pwm_out    = pwm_q;
  assign clip_out   = clip_q;
  assign level_out  = level_q;
  assign aud_sd_out = (state_q != MUTED);
endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed bench for pwm_audio_out: table-driven sample-path vectors plus
// hand-written reset, underrun, mute-ramp and mid-ramp reset sequences.
module tb_pwm_audio_out;
  logic        clk_in = 1'b0, rst_in = 1'b0;
  logic [15:0] sample_in = '0;
  logic        valid_in = 1'b0;
  logic [3:0]  shift_in = '0;
  logic [2:0]  vol_in = 3'd7;
  logic        mute_in = 1'b0;
  logic        pwm_out, aud_sd_out, clip_out, underrun_out;
  logic [7:0]  level_out;

  int nvec = 0, nerr = 0;
  int tcnt = 0;

  always #5 clk_in = ~clk_in;

  pwm_audio_out #(.SAMPLE_W(16), .PWM_W(8), .SHIFT_W(4), .RAMP_STEP(4), .HOLD_PERIODS(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .sample_in(sample_in), .valid_in(valid_in),
    .shift_in(shift_in), .vol_in(vol_in), .mute_in(mute_in), .pwm_out(pwm_out),
    .aud_sd_out(aud_sd_out), .level_out(level_out), .clip_out(clip_out),
    .underrun_out(underrun_out));

  typedef struct {
    logic [15:0] smp;
    logic [3:0]  sh;
    logic [2:0]  vol;
    int          lvl;
    logic        clip;
  } vec_t;
  localparam int NV = 11;
  vec_t vt[NV];

  // tcnt tracks the DUT period counter independently
  task automatic tick();
    @(posedge clk_in);
    tcnt = rst_in ? (tcnt + 1) % 256 : 0;
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_cnt(input int v);
    do tick(); while (tcnt != v);
  endtask

  task automatic send(input logic [15:0] s, input logic [3:0] sh, input logic [2:0] v);
    sample_in = s; shift_in = sh; vol_in = v; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic feed(input logic [15:0] s, input logic [3:0] sh, input logic [2:0] v);
    wait_cnt(10);
    send(s, sh, v);
    wait_cnt(0);
  endtask

  task automatic count_pwm(output int n);
    n = 0;
    repeat (256) begin
      tick();
      n += int'(pwm_out);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    vt[0]  = '{16'h4000, 4'd0,  3'd7, 192, 1'b0};
    vt[1]  = '{16'h4000, 4'd2,  3'd7, 255, 1'b1};
    vt[2]  = '{16'h8000, 4'd1,  3'd7, 0,   1'b1};
    vt[3]  = '{16'h4000, 4'd0,  3'd5, 144, 1'b0};
    vt[4]  = '{16'hC000, 4'd0,  3'd5, 112, 1'b0};
    vt[5]  = '{16'h0001, 4'd15, 3'd7, 255, 1'b1};
    vt[6]  = '{16'hFFFF, 4'd15, 3'd7, 0,   1'b0};
    vt[7]  = '{16'h0100, 4'd0,  3'd7, 129, 1'b0};
    vt[8]  = '{16'hFF00, 4'd0,  3'd7, 127, 1'b0};
    vt[9]  = '{16'h8000, 4'd0,  3'd0, 127, 1'b0};
    vt[10] = '{16'h7FFF, 4'd0,  3'd6, 191, 1'b0};

    // reset and release
    repeat (10) tick();
    chk("rst_level", level_out, 128);
    chk("rst_sd", aud_sd_out, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_clip", clip_out, 0);
    chk("rst_urun", underrun_out, 0);
    rst_in = 1'b1;
    wait_cnt(255);
    chk("sd_before_b1", aud_sd_out, 0);
    tick();
    chk("sd_after_b1", aud_sd_out, 1);
    chk("level_after_b1", level_out, 128);
    count_pwm(n);
    chk("duty_mid", n, 128);
    wait_cnt(255);
    tick();
    wait_cnt(255);
    chk("urun_before_b4", underrun_out, 0);
    tick();
    chk("urun_after_b4", underrun_out, 1);
    wait_cnt(0);
    chk("sd_b5_rampdown", aud_sd_out, 1);
    chk("level_b5", level_out, 128);
    wait_cnt(0);
    chk("sd_b6_muted", aud_sd_out, 0);

    // a sample clears underrun and the block ramps up to 192
    wait_cnt(10);
    send(16'h4000, 4'd0, 3'd7);
    chk("urun_clear_t1", underrun_out, 0);
    tick();
    chk("clip_nominal", clip_out, 0);
    wait_cnt(0);
    chk("sd_rampup", aud_sd_out, 1);
    chk("level_rampup_start", level_out, 128);
    for (int k = 1; k <= 16; k++) begin
      feed(16'h4000, 4'd0, 3'd7);
      chk($sformatf("rampup_%0d", k), level_out, 128 + 4 * k);
    end

    // sample path vectors, applied in RUN
    for (int i = 0; i < NV; i++) begin
      wait_cnt(10);
      send(vt[i].smp, vt[i].sh, vt[i].vol);
      tick();
      chk($sformatf("vec%0d_clip", i), clip_out, vt[i].clip);
      tick();
      chk($sformatf("vec%0d_clip_end", i), clip_out, 0);
      wait_cnt(0);
      chk($sformatf("vec%0d_level", i), level_out, vt[i].lvl);
      count_pwm(n);
      chk($sformatf("vec%0d_duty", i), n, vt[i].lvl);
    end

    // mute ramp down and back up
    feed(16'h4000, 4'd0, 3'd7);
    chk("pre_mute_level", level_out, 192);
    mute_in = 1'b1;
    feed(16'h4000, 4'd0, 3'd7);
    chk("mute_exit_run_level", level_out, 192);
    for (int k = 1; k <= 16; k++) begin
      feed(16'h4000, 4'd0, 3'd7);
      chk($sformatf("rampdn_%0d", k), level_out, 192 - 4 * k);
      if (k == 15) chk("sd_rampdn_15", aud_sd_out, 1);
    end
    chk("sd_muted", aud_sd_out, 0);
    mute_in = 1'b0;
    feed(16'h4000, 4'd0, 3'd7);
    chk("sd_unmute", aud_sd_out, 1);
    chk("unmute_level", level_out, 128);
    for (int k = 1; k <= 16; k++) begin
      feed(16'h4000, 4'd0, 3'd7);
      chk($sformatf("unmute_up_%0d", k), level_out, 128 + 4 * k);
    end
    // mute pulse entirely inside a period is ignored
    wait_cnt(10);
    send(16'h4000, 4'd0, 3'd7);
    wait_cnt(50);
    mute_in = 1'b1;
    wait_cnt(100);
    mute_in = 1'b0;
    wait_cnt(0);
    chk("glitch_level", level_out, 192);
    chk("glitch_sd", aud_sd_out, 1);
    feed(16'h4000, 4'd0, 3'd5);
    chk("run_jump_144", level_out, 144);

    // underrun from 192, recovery mid-ramp
    feed(16'h4000, 4'd0, 3'd7);
    chk("urun_start_level", level_out, 192);
    wait_cnt(0);
    wait_cnt(0);
    wait_cnt(255);
    chk("urun2_before", underrun_out, 0);
    tick();
    chk("urun2_after", underrun_out, 1);
    wait_cnt(0);
    chk("urun2_b5", level_out, 192);
    wait_cnt(0);
    chk("urun2_b6", level_out, 188);
    wait_cnt(0);
    chk("urun2_b7", level_out, 184);
    wait_cnt(10);
    send(16'h4000, 4'd0, 3'd7);
    chk("urun2_clear", underrun_out, 0);
    wait_cnt(0);
    chk("urun2_b8", level_out, 180);
    feed(16'h4000, 4'd0, 3'd7);
    chk("urun2_b9_up", level_out, 184);

    // reset mid-ramp with a clipping sample in flight
    wait_cnt(40);
    send(16'h4000, 4'd2, 3'd7);
    rst_in = 1'b0;
    tick();
    chk("mrst_level", level_out, 128);
    chk("mrst_sd", aud_sd_out, 0);
    chk("mrst_pwm", pwm_out, 0);
    chk("mrst_clip", clip_out, 0);
    chk("mrst_urun", underrun_out, 0);
    rst_in = 1'b1;
    tick();
    chk("mrst_clip_flush", clip_out, 0);
    wait_cnt(0);
    chk("mrst_sd_b1", aud_sd_out, 1);
    wait_cnt(0);
    chk("mrst_target_mid", level_out, 128);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/pwm_audio_out.md
# pwm_audio_out

Parametrised mono audio output stage. It replaces the fixed 8-bit volume/PWM pair. It accepts signed samples on a valid strobe, then applies a left-shift gain with saturation and a 3-bit attenuation. The result drives a glitch-free PWM whose level changes only at period boundaries. Mute and sample-underrun are handled with a slew-limited ramp to midscale and an amplifier-enable output. It sits between the FIR anti-noise output and the `aud_pwm`/`aud_sd` pins.

## Interface
- SAMPLE_W, 16: input sample width, signed two's complement.
- PWM_W, 8: PWM resolution. Period is 2^PWM_W cycles. Midscale MID = 2^(PWM_W-1).
- SHIFT_W, 4: width of the gain shift control.
- RAMP_STEP, 4: maximum level change per PWM period while ramping.
- HOLD_PERIODS, 64: number of whole PWM periods without `valid_in` before underrun is declared.
- clk_in  in  1  system clock (100 MHz).
- rst_in  in  1  synchronous, active-low reset.
- sample_in  in  SAMPLE_W  signed sample.
- valid_in  in  1  one-cycle strobe qualifying `sample_in`.
- shift_in  in  SHIFT_W  gain as a left shift, 0..2^SHIFT_W-1.
- vol_in  in  3  attenuation; right shift by 7-vol_in.
- mute_in  in  1  request mute (level), sampled at period boundaries.
- pwm_out  out  1  registered PWM bit.
- aud_sd_out  out  1  amplifier enable; 0 only in MUTED.
- level_out  out  PWM_W  currently applied offset-binary duty.
- clip_out  out  1  one-cycle pulse when a sample saturated.
- underrun_out  out  1  high while underrun is active.

## Operation
- Sample path: two register stages, fired by `valid_in`.
  - S1: form `sample_in <<< shift_in` at SAMPLE_W+2^SHIFT_W bits, then saturate to SAMPLE_W (max 2^(SAMPLE_W-1)-1, min -2^(SAMPLE_W-1)). Record a clip flag.
  - S2: take the top PWM_W bits (arithmetic), `>>>` by (7-vol_in), and invert the MSB to make offset binary. Write the result to `target` and pulse `clip_out` if S1 clipped.
- `shift_in` and `vol_in` are sampled in the cycle they are used (S1 and S2 respectively).
- Counter: PWM_W-bit `cnt` increments every cycle and wraps. Boundary = the cycle where `cnt` == all-ones.
- `pwm_out` <= (`cnt` < `level`).
- Underrun:
  - `idle_periods` is cleared by `valid_in` and increments at each boundary, saturating at HOLD_PERIODS.
  - `underrun_out` = (`idle_periods` == HOLD_PERIODS).
  - On underrun, `target` is forced to MID.
- Effective mute: `em` = `mute_in` | `underrun_out`.
- FSM, evaluated only at boundaries. It updates `level` for the next period.
  - RUN: `level` <= `target`. If `em`, go to RAMP_DOWN. Levels on the boundary where RUN exits are unchanged.
  - RAMP_DOWN: `level` steps toward MID by ≤RAMP_STEP without overshoot.
    - If `level` reaches MID: go to MUTED.
    - Else if !`em`: go to RAMP_UP.
  - MUTED: `level` = MID, `aud_sd_out` = 0. If !`em`, go to RAMP_UP.
  - RAMP_UP: `level` steps toward live `target` by ≤RAMP_STEP without overshoot.
    - If `em`: go to RAMP_DOWN.
    - Else if `level` == `target` after the step: go to RUN.
- Reset values:
  - `cnt` = 0, `level` = MID, `target` = MID, `level_out` = MID.
  - `pwm_out` = 0, `clip_out` = 0, `underrun_out` = 0.
  - `idle_periods` = 0, state MUTED, `aud_sd_out` = 0.
- Reset mid-operation: all of the above are restored on the next clock edge. In-flight S1/S2 data is discarded.

## Timing
- `valid_in` at cycle T: `target` and `clip_out` update at T+2. The new `level` applies at the first boundary ≥ T+2. `pwm_out` reflects it one cycle after `cnt` returns to 0.
- Worst-case sample-to-PWM latency: 2 + 2^PWM_W + 1 cycles.
- Back-to-back `valid_in`: every strobe is accepted. The last `target` before a boundary wins.
- `valid_in` in a boundary cycle: the boundary uses the pre-existing `target`.
- `valid_in` clears underrun at T+1. `target` is then from the new sample at T+2.
- `mute_in` toggling within a period has no effect unless it is high or low at the boundary.
- `level_out` and `aud_sd_out` change only in the cycle after a boundary, or on reset.
- Ramp duration: ceil(|level-goal| / RAMP_STEP) periods.

## Test plan
All scenarios use SAMPLE_W=16, PWM_W=8, RAMP_STEP=4, HOLD_PERIODS=4.
- Reset and release:
  - Stimulus: hold `rst_in`=0 for 10 cycles; release with `mute_in`=0 and no samples.
  - Required response: `aud_sd_out`=0 until the first boundary, then RAMP_UP→RUN. `level_out`=128. `pwm_out` high 128 of every 256 cycles. Once 4 idle periods elapse, underrun sends the block to MUTED.
- Nominal gain:
  - Stimulus: `shift_in`=0, `vol_in`=7, sample 0x4000 every 64 cycles.
  - Required response: `level_out`=192 and 192/256 duty. `clip_out` never pulses.
- Saturation:
  - Stimulus A: sample 0x4000 with `shift_in`=2. Stimulus B: sample 0x8000 with `shift_in`=1.
  - Required response A: `clip_out` pulse at T+2 and `level_out`=255.
  - Required response B: clip pulse and `level_out`=0, so `pwm_out` stays 0 for the whole period.
- Attenuation:
  - Stimulus: sample 0x4000, `shift_in`=0, `vol_in`=5.
  - Required response: `level_out`=144. With sample 0xC000, `level_out`=112.
- Mute ramp:
  - Stimulus: at `level` 192, assert `mute_in`.
  - Required response: `level_out` goes 192→188→…→128 over 16 periods, then MUTED with `aud_sd_out`=0.
  - Stimulus: deassert `mute_in`.
  - Required response: `aud_sd_out`=1 after the next boundary, then a 16-period ramp back to 192, then RUN.
- Underrun and mid-ramp reset:
  - Stimulus: stop samples at `level` 192.
  - Required response: after 4 boundaries `underrun_out`=1 and the ramp down starts.
  - Stimulus: one `valid_in` (0x4000) mid-ramp.
  - Required response: `underrun_out` clears and the block ramps up to 192.
  - Stimulus: assert `rst_in`=0 mid-ramp.
  - Required response: all outputs at their reset values on the next cycle.
